// File: rtl/sound_sample_player.sv
// sound_sample_player: streams SAMPLE_COUNT 16-bit PCM words from a
// synchronous sample ROM to an Avalon-ST sink, one word per sample tick.
// Optional feature macro: SOUND_SAMPLE_PLAYER_LOOP_EN adds a 'loop' input
// that restarts playback from address 0 instead of returning to IDLE.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | not playing; waits for start
// WAIT_TICK | playing; waits for the next sample tick
// READ      | ROM enabled for one cycle at the current address
// CAPTURE   | ROM word valid; latched into sample_data, address advanced
// PRESENT   | sample_valid held until the sink accepts the word
module sound_sample_player #(
   parameter int SAMPLE_COUNT = 9000,
   parameter int ADDR_W       = 14,
   parameter int CLK_DIV      = 1042
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              stop,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_address,
   output logic              rom_clken,
   output logic              rom_chipselect,
   input  logic [15:0]       rom_readdata,
   output logic [15:0]       sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [7:0]        underrun_count
`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
   ,
   input  logic              loop
`endif
);

   localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
   // When SAMPLE_COUNT == 2**ADDR_W this truncates to 0, which is exactly
   // where the address lands after wrapping past the last word.
   localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(SAMPLE_COUNT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_TICK,
      S_READ,
      S_CAPTURE,
      S_PRESENT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       data_q, data_d;
   logic              valid_q, valid_d;
   logic              clken_q, clken_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [7:0]        under_q, under_d;
   logic              tick;
   logic              handshake;
   logic              loop_en;

`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
   assign loop_en = loop;
`else
   assign loop_en = 1'b0;
`endif

   // Free-running sample-rate divider; tick marks the cycle the count wraps.
   always_comb begin
      tick       = (tick_cnt_q == CNT_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
   end

   assign handshake = valid_q & sample_ready;

   // Next-state and next-output logic; stop overrides every other decision.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      clken_d = 1'b0;
      done_d  = 1'b0;
      under_d = under_q;

      // A tick seen while a word is still waiting is dropped, not queued.
      if (state_q == S_PRESENT && tick && under_q != 8'hFF) begin
         under_d = under_q + 8'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = '0;
               state_d = S_WAIT_TICK;
            end
         end
         S_WAIT_TICK: begin
            if (tick) begin
               clken_d = 1'b1;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            data_d  = rom_readdata;
            valid_d = 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = S_PRESENT;
         end
         S_PRESENT: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (addr_q == ADDR_END) begin
                  done_d = 1'b1;
                  if (loop_en) begin
                     addr_d  = '0;
                     state_d = S_WAIT_TICK;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  state_d = S_WAIT_TICK;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (stop) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
         clken_d = 1'b0;
         done_d  = 1'b0;
      end
   end

   assign busy_d = (state_d != S_IDLE);

   // State and registered outputs; reset abandons any pending handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         clken_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         under_q    <= '0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         clken_q    <= clken_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         under_q    <= under_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign rom_address    = addr_q;
   assign rom_clken      = clken_q;
   assign rom_chipselect = clken_q;
   assign sample_data    = data_q;
   assign sample_valid   = valid_q;
   assign underrun_count = under_q;

endmodule

// File: tb/tb_sound_sample_player.sv
// Bench for sound_sample_player: a timeline model derived from the tick
// period, the T+1 ROM enable / T+3 valid latency and the handshake rules
// predicts every output cycle for randomized sink back-pressure.
module tb_sound_sample_player;

   localparam int CLK_DIV = 8;
   localparam int ADDR_W  = 4;
`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
   localparam int N = 3;
`else
   localparam int N = 4;
`endif
   localparam int MAXC = 600;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              sample_ready = 1'b0;
   logic              busy, done, rom_clken, rom_chipselect, sample_valid;
   logic [ADDR_W-1:0] rom_address;
   logic [15:0]       rom_readdata, sample_data;
   logic [7:0]        underrun_count;
`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
   logic              loop = 1'b0;
`endif

   logic [15:0] rom_mem [16];
   logic [15:0] rom_rd = 16'h0000;

   int cyc;
   int n_tests = 0;
   int n_fail  = 0;
   int exp_under = 0;

   bit          exp_valid [MAXC];
   bit          exp_clken [MAXC];
   bit          exp_done  [MAXC];
   bit          exp_busy  [MAXC];
   bit          rdy       [MAXC];
   logic [15:0] exp_data  [MAXC];
   logic [ADDR_W-1:0] exp_addr [MAXC];

   sound_sample_player #(
      .SAMPLE_COUNT(N),
      .ADDR_W(ADDR_W),
      .CLK_DIV(CLK_DIV)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .stop(stop),
      .busy(busy),
      .done(done),
      .rom_address(rom_address),
      .rom_clken(rom_clken),
      .rom_chipselect(rom_chipselect),
      .rom_readdata(rom_readdata),
      .sample_data(sample_data),
      .sample_valid(sample_valid),
      .sample_ready(sample_ready),
      .underrun_count(underrun_count)
`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
      ,
      .loop(loop)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous ROM: address registered on an enabled edge, data out after.
   always @(posedge clk) if (rom_clken) rom_rd <= rom_mem[rom_address];
   assign rom_readdata = rom_rd;

   // Edges since reset release; cycle k has divider count k mod CLK_DIV.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int next_tick(input int from);
      int k = from;
      while (k % CLK_DIV != CLK_DIV - 1) k++;
      return k;
   endfunction

   task automatic chk_quiet(input string tag, input int cycles);
      for (int j = 0; j < cycles; j++) begin
         chk({tag, ".busy"}, busy, 1'b0);
         chk({tag, ".valid"}, sample_valid, 1'b0);
         chk({tag, ".clken"}, rom_clken, 1'b0);
         chk({tag, ".done"}, done, 1'b0);
         step();
      end
   endtask

   // Start playback now and check every output cycle against the timeline.
   task automatic play(input int total, input int pct, input int low_from_in, input int low_len,
                       input int restart_at, input bit do_loop, input string tag);
      int s, t, k, h, last, low_from;
      s = cyc;
      k = next_tick(s + 1);
      low_from = (low_from_in < 0) ? (k + 3 - s) : low_from_in;
      for (int j = 0; j < MAXC; j++) begin
         exp_valid[j] = 1'b0; exp_clken[j] = 1'b0; exp_done[j] = 1'b0;
         exp_busy[j]  = 1'b0; exp_data[j]  = '0;   exp_addr[j] = '0;
         rdy[j] = ($urandom_range(99) < pct);
         if (j >= low_from && j < low_from + low_len) rdy[j] = 1'b0;
      end
      t = s + 1;
      for (int i = 0; i < total; i++) begin
         k = next_tick(t);
         if (k + 4 - s >= MAXC - 8) break;
         exp_clken[k + 1 - s] = 1'b1;
         exp_addr[k + 1 - s]  = ADDR_W'(i % N);
         h = k + 3;
         while ((h - s) < MAXC - 8 && !rdy[h - s]) h++;
         for (int m = k + 3; m <= h; m++) begin
            exp_valid[m - s] = 1'b1;
            exp_data[m - s]  = rom_mem[i % N];
            if (m % CLK_DIV == CLK_DIV - 1 && exp_under < 255) exp_under++;
         end
         if (i % N == N - 1) exp_done[h + 1 - s] = 1'b1;
         t = h + 1;
      end
      last = t - s;
      if (last + 4 >= MAXC) begin
         n_tests++; n_fail++;
         $error("FAIL %s.bound observed=%0d expected<%0d", tag, last, MAXC - 4);
         last = MAXC - 5;
      end
      for (int j = 1; j < last; j++) exp_busy[j] = 1'b1;
      if (do_loop) exp_busy[last] = 1'b1;

      for (int j = 0; j <= last + 3; j++) begin
         chk({tag, ".valid"}, sample_valid, exp_valid[j]);
         chk({tag, ".clken"}, rom_clken, exp_clken[j]);
         chk({tag, ".cs"}, rom_chipselect, exp_clken[j]);
         chk({tag, ".done"}, done, exp_done[j]);
         chk({tag, ".busy"}, busy, exp_busy[j]);
         if (exp_valid[j]) chk({tag, ".data"}, sample_data, exp_data[j]);
         if (exp_clken[j]) chk({tag, ".addr"}, rom_address, exp_addr[j]);
         start = (j == 0 || j == restart_at);
         stop  = do_loop && (j == last);
         sample_ready = rdy[j];
         step();
      end
      start = 1'b0;
      stop  = 1'b0;
      chk({tag, ".under"}, underrun_count, exp_under);
   endtask

   initial begin
      int k, u0;
      for (int i = 0; i < 16; i++)
         rom_mem[i] = (i < N) ? 16'(16'h1111 * (i + 1)) : 16'($urandom);

      // Reset values while reset is held.
      #23;
      chk("rst.busy", busy, 1'b0);
      chk("rst.done", done, 1'b0);
      chk("rst.valid", sample_valid, 1'b0);
      chk("rst.clken", rom_clken, 1'b0);
      chk("rst.cs", rom_chipselect, 1'b0);
      chk("rst.addr", rom_address, '0);
      chk("rst.data", sample_data, 16'h0000);
      chk("rst.under", underrun_count, 8'h00);
      @(negedge clk) reset_n = 1'b1;
      step();

      // Ready tied high: N words, one per tick period, no underruns.
      play(N, 100, 0, 0, -1, 1'b0, "basic");
      chk("basic.under0", underrun_count, 8'h00);
      repeat (3) step();

      // Sink stalls for 20 cycles on the first word: two ticks dropped.
      u0 = exp_under;
      play(N, 100, -1, 20, -1, 1'b0, "stall");
      chk("stall.under2", underrun_count, 8'(u0 + 2));

      // Randomized back-pressure and idle gaps.
      for (int r = 0; r < 4; r++) begin
         repeat ($urandom_range(6)) step();
         play(N, 30 + $urandom_range(60), 0, 0, -1, 1'b0, "rand");
      end

      // Start pulse while busy must not restart the sequence.
      play(N, 70, 0, 0, 15, 1'b0, "restart");

      // Stop while a word is presented.
      k = next_tick(cyc + 1);
      start = 1'b1; sample_ready = 1'b0;
      step();
      start = 1'b0;
      while (cyc < k + 4) step();
      chk("stop.valid_before", sample_valid, 1'b1);
      chk("stop.data_before", sample_data, rom_mem[0]);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk_quiet("stop", 12);
      play(N, 100, 0, 0, -1, 1'b0, "after_stop");

      // Reset asserted while the ROM read is in progress.
      k = next_tick(cyc + 1);
      start = 1'b1; sample_ready = 1'b1;
      step();
      start = 1'b0;
      while (cyc < k + 1) step();
      chk("rstread.clken_before", rom_clken, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      chk("rstread.busy", busy, 1'b0);
      chk("rstread.valid", sample_valid, 1'b0);
      chk("rstread.clken", rom_clken, 1'b0);
      chk("rstread.done", done, 1'b0);
      chk("rstread.addr", rom_address, '0);
      chk("rstread.under", underrun_count, 8'h00);
      @(negedge clk) reset_n = 1'b1;
      exp_under = 0;
      step();
      play(N, 100, 0, 0, -1, 1'b0, "after_rst");

      // Start and stop together: stop wins.
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      chk_quiet("startstop", 12);

`ifdef SOUND_SAMPLE_PLAYER_LOOP_EN
      // Looping: wraps to address 0 with done on each wrap, busy stays high.
      loop = 1'b1;
      play(2 * N + 2, 80, 0, 0, -1, 1'b1, "loop");
      loop = 1'b0;
      chk_quiet("loop_end", 4);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sound_sample_player.md
SOUND_SAMPLE_PLAYER -- requirements
Module: sound_sample_player

Interface
REQ-001 SHALL have parameter SAMPLE_COUNT, default 9000: number of 16-bit words played from the sample ROM.
REQ-002 SHALL have parameter ADDR_W, default 14: sample ROM address width.
REQ-003 SHALL have parameter CLK_DIV, default 1042: clk cycles per sample tick (50 MHz to about 48 kHz).
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle pulse that begins playback from address 0.
REQ-007 SHALL have port stop, input, 1: single-cycle pulse that aborts playback.
REQ-008 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse when the last sample is accepted.
REQ-010 SHALL have port rom_address, output, ADDR_W: sample ROM address, driven from a register.
REQ-011 SHALL have port rom_clken, output, 1: sample ROM clock enable.
REQ-012 SHALL have port rom_chipselect, output, 1: equal to rom_clken.
REQ-013 SHALL have port rom_readdata, input, 16: unregistered ROM data, valid the cycle after the address edge.
REQ-014 SHALL have port sample_data, output, 16: signed PCM sample to the audio stream sink.
REQ-015 SHALL have port sample_valid, output, 1: Avalon-ST valid.
REQ-016 SHALL have port sample_ready, input, 1: Avalon-ST ready.
REQ-017 SHALL have port underrun_count, output, 8: saturating count of dropped ticks.

Function
REQ-018 SHALL run a tick counter from 0 to CLK_DIV-1 continuously from reset, pulsing an internal tick when the count wraps to 0.
REQ-019 SHALL implement states IDLE, WAIT_TICK, READ, CAPTURE, PRESENT.
REQ-020 IDLE: on start, SHALL clear rom_address to 0 and go to WAIT_TICK.
REQ-021 WAIT_TICK: on tick, SHALL go to READ.
REQ-022 READ: SHALL assert rom_clken and rom_chipselect for exactly one cycle with rom_address held stable, then go to CAPTURE.
REQ-023 CAPTURE: SHALL latch rom_readdata into sample_data, set sample_valid, increment rom_address, and go to PRESENT.
REQ-024 Timing: a tick in cycle T SHALL produce sample_valid high from cycle T+3.
REQ-025 PRESENT: SHALL hold sample_valid and sample_data stable until sample_valid and sample_ready are both high on the same edge.
REQ-026 On that handshake, sample_valid SHALL drop the next cycle.
REQ-027 After the handshake, if rom_address equals SAMPLE_COUNT, the block SHALL pulse done and go to IDLE; otherwise it SHALL go to WAIT_TICK.
REQ-028 A tick arriving in PRESENT, or in the same cycle as the PRESENT handshake, SHALL increment underrun_count (saturating at 255) and SHALL be discarded, not deferred.
REQ-029 Stop in any state SHALL go to IDLE on the next edge and clear sample_valid; done SHALL NOT pulse.
REQ-030 Start while busy SHALL be ignored.
REQ-031 Start and stop in the same cycle: stop SHALL win.
REQ-032 rom_address arithmetic SHALL be ADDR_W-bit unsigned; SAMPLE_COUNT must be at most 2^ADDR_W.
REQ-033 underrun_count SHALL clear only on reset.

Reset
REQ-034 On reset_n low, asynchronously: state IDLE; rom_address, sample_data, underrun_count and the tick counter all 0; busy, done, sample_valid, rom_clken and rom_chipselect all 0.
REQ-035 Reset asserted mid-playback SHALL abort without a done pulse, and it SHALL NOT be possible for a partial handshake to occur.

Configuration
REQ-036 SHALL use the macro SOUND_SAMPLE_PLAYER_LOOP_EN.
REQ-037 With SOUND_SAMPLE_PLAYER_LOOP_EN defined: the block SHALL add input port loop (1 bit).
REQ-038 With the macro defined and loop high at the final handshake: the block SHALL pulse done, reset rom_address to 0, and go to WAIT_TICK instead of IDLE.
REQ-039 With SOUND_SAMPLE_PLAYER_LOOP_EN undefined: the loop port SHALL be absent and REQ-027 SHALL apply unchanged.

Verification
REQ-040 Test: CLK_DIV=8, SAMPLE_COUNT=4, ROM holds 0x1111/0x2222/0x3333/0x4444, sample_ready tied high, start -> exactly 4 samples in order, one per 8 cycles; done pulses once; busy then drops; underrun_count=0.
REQ-041 Test: tick at cycle T -> rom_clken high at T+1 only; sample_valid high from T+3.
REQ-042 Test: sample_ready held low for 20 cycles with CLK_DIV=8 -> sample_data stable; underrun_count=2 (or 3 if the handshake edge coincides with a tick); playback then resumes at the next address.
REQ-043 Test: stop during PRESENT, and separately reset_n low during READ -> IDLE, sample_valid 0, no done pulse; a following start replays from address 0.
REQ-044 Test: start and stop in the same cycle -> remains IDLE; start while busy -> no restart, address sequence unchanged.
REQ-045 Test: SOUND_SAMPLE_PLAYER_LOOP_EN defined, loop=1, SAMPLE_COUNT=3 -> data sequence 0,1,2,0,1,...; done pulses on every wrap; busy stays high.
